// File: rtl/hub75_scan_if.sv
// Frame buffer read port between hub75_scan and the pixel RAM.
// The RAM returns rd_data one cycle after it sees rd_addr.
interface hub75_scan_if #(
  parameter int unsigned AW = 10
);
  logic [AW-1:0] rd_addr;
  logic [23:0]   rd_data;

  modport master (output rd_addr, input rd_data);
  modport slave  (input rd_addr, output rd_data);
endinterface

// File: rtl/hub75_scan.sv
// HUB75 dual-scan panel driver: shifts one bit plane of a row pair while the
// previously latched plane is displayed with a binary-weighted OE on-time.
module hub75_scan #(
  parameter int unsigned COLS      = 64,
  parameter int unsigned ROW_ADDRS = 8,
  parameter int unsigned BITS      = 8,
  parameter int unsigned OE_BASE   = 8
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         enable,
  hub75_scan_if.master                 fb,
  output logic                         hub75_clk,
  output logic                         hub75_lat,
  output logic                         hub75_oe_,
  output logic [$clog2(ROW_ADDRS)-1:0] hub75_row,
  output logic                         hub75_r0,
  output logic                         hub75_g0,
  output logic                         hub75_b0,
  output logic                         hub75_r1,
  output logic                         hub75_g1,
  output logic                         hub75_b1,
  output logic                         frame_start
);
  localparam int unsigned CW = $clog2(COLS);
  localparam int unsigned RW = $clog2(ROW_ADDRS);
  localparam int unsigned BW = (BITS > 1) ? $clog2(BITS) : 1;
  localparam int unsigned AW = $clog2(2 * ROW_ADDRS * COLS);
  localparam int unsigned TW = $clog2((OE_BASE << (BITS - 1)) + 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_BLANK,
    S_LATCH,
    S_DISPLAY
  } state_t;

  state_t state, state_next;

  logic [1:0]    phase;
  logic [CW-1:0] col;
  logic [RW-1:0] sh_row;
  logic [BW-1:0] sh_bit;
  logic          sh_done;
  logic [23:0]   top_q;
  logic [5:0]    pix_q;
  logic [TW-1:0] timer;
  logic [TW-1:0] timer_next;
  logic [RW-1:0] row_q;

  logic          advance;
  logic          done_next;
  logic [4:0]    idx_r, idx_g, idx_b;
  logic [5:0]    pix_new;
  logic [5:0]    pix_out;
  logic [AW-1:0] row_base;

  // A started plane always runs to completion; only a fresh plane waits for enable.
  always_comb begin
    advance   = !sh_done && (enable || phase != 2'd0 || col != '0);
    done_next = sh_done || (advance && phase == 2'd3 && col == CW'(COLS - 1));

    idx_r = 5'(sh_bit);
    idx_g = idx_r + 5'd8;
    idx_b = idx_r + 5'd16;
    pix_new = {fb.rd_data[idx_b], fb.rd_data[idx_g], fb.rd_data[idx_r],
               top_q[idx_b], top_q[idx_g], top_q[idx_r]};

    row_base   = AW'(sh_row) + (phase[0] ? AW'(ROW_ADDRS) : '0);
    fb.rd_addr = row_base * AW'(COLS) + AW'(col);
  end

  // BLANK is entered in the cycle where both the shift and the display have finished.
  always_comb begin
    timer_next = timer;
    if (state == S_DISPLAY && timer != '0) timer_next = timer - TW'(1);

    state_next = state;
    case (state)
      S_IDLE, S_DISPLAY:
        if (enable && done_next && timer_next == '0) state_next = S_BLANK;
      S_BLANK: state_next = S_LATCH;
      S_LATCH: state_next = S_DISPLAY;
      default: state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) state <= S_IDLE;
    else       state <= state_next;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      timer <= '0;
      row_q <= '0;
    end else begin
      timer <= (state == S_LATCH) ? (TW'(OE_BASE) << sh_bit) : timer_next;
      if (state == S_BLANK) row_q <= sh_row;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      phase   <= 2'd0;
      col     <= '0;
      sh_row  <= '0;
      sh_bit  <= '0;
      sh_done <= 1'b0;
      top_q   <= '0;
      pix_q   <= '0;
    end else if (state == S_LATCH) begin
      phase   <= 2'd0;
      col     <= '0;
      sh_done <= 1'b0;
      if (sh_bit == BW'(BITS - 1)) begin
        sh_bit <= '0;
        sh_row <= (sh_row == RW'(ROW_ADDRS - 1)) ? '0 : sh_row + RW'(1);
      end else begin
        sh_bit <= sh_bit + BW'(1);
      end
    end else if (advance) begin
      phase <= phase + 2'd1;
      if (phase == 2'd1) top_q <= fb.rd_data;
      if (phase == 2'd2) pix_q <= pix_new;
      if (phase == 2'd3) begin
        if (col == CW'(COLS - 1)) begin
          col     <= '0;
          sh_done <= 1'b1;
        end else begin
          col <= col + CW'(1);
        end
      end
    end
  end

  // Bottom pixel arrives during phase 2, so colour pins bypass the hold register
  // then to be stable a full cycle before the shift clock rises.
  assign pix_out     = (phase == 2'd2) ? pix_new : pix_q;
  assign hub75_r0    = pix_out[0];
  assign hub75_g0    = pix_out[1];
  assign hub75_b0    = pix_out[2];
  assign hub75_r1    = pix_out[3];
  assign hub75_g1    = pix_out[4];
  assign hub75_b1    = pix_out[5];

  assign hub75_clk   = (phase == 2'd3);
  assign hub75_lat   = (state == S_LATCH);
  assign hub75_oe_   = !(state == S_DISPLAY && timer != '0);
  assign hub75_row   = row_q;
  assign frame_start = (state == S_LATCH) && sh_row == '0 && sh_bit == '0;
endmodule

// File: doc/hub75_scan.md
# hub75_scan

HUB75 scan controller that sits directly upstream of the LED panel. It reads 24-bit pixels from the frame buffer read port, shifts one bit plane of one dual-scan row pair into the panel, latches it, and drives the output enable with binary-weighted on-times (BCM). The next plane is shifted while the current one is displayed. Its outputs are the panel pins driven by CubeTop.

## Interface
- COLS, 64: columns per panel row.
- ROW_ADDRS, 8: row addresses. Panel height is 2*ROW_ADDRS; top and bottom halves are driven together.
- BITS, 8: bit planes per colour.
- OE_BASE, 8: `hub75_oe_`-low cycles for bit plane 0.
- clk  in  1: system clock; all logic on rising edge.
- reset  in  1: synchronous, active-high.
- enable  in  1: run scanning; when low, stop at the next plane boundary.
- rd_addr  out  log2(2*ROW_ADDRS*COLS): frame buffer address, pixel index = row*COLS + col.
- rd_data  in  24: pixel returned one cycle after rd_addr; [7:0]=R, [15:8]=G, [23:16]=B.
- hub75_clk  out  1: panel shift clock; the panel samples on the rising edge.
- hub75_lat  out  1: latch pulse.
- hub75_oe_  out  1: output enable, active-low.
- hub75_row  out  log2(ROW_ADDRS): row address.
- hub75_r0/g0/b0  out  1 each: top-half colour bits (row).
- hub75_r1/g1/b1  out  1 each: bottom-half colour bits (row+ROW_ADDRS).
- frame_start  out  1: one-cycle pulse that coincides with the latch of (row 0, bit 0).

## Operation
- **Plane order:** bit 0..BITS-1 within a row, then the next row; row ROW_ADDRS-1 wraps to 0.
- **Shifter:**
  - Loads plane (r, b) using 4 cycles per column c.
  - Phase 0: rd_addr = r*COLS+c.
  - Phase 1: rd_addr = (r+ROW_ADDRS)*COLS+c; capture top pixel.
  - Phase 2: capture bottom pixel; drive hub75_r0=top[b], g0=top[8+b], b0=top[16+b], r1/g1/b1 from bottom likewise; hub75_clk=0.
  - Phase 3: hub75_clk=1, data held.
  - After column COLS-1 phase 3 the shifter is done and idles until the latch.
- **Display timer:** counts down the oe_-low cycles of the currently latched plane.
- **Latch sequencer states:**
  - IDLE: oe_=1.
  - BLANK: 1 cycle, oe_=1.
  - LATCH: 1 cycle. hub75_lat=1, oe_=1, hub75_row←r of the plane just shifted, frame_start=1 if (r,b)=(0,0), timer loaded with OE_BASE<<b, shifter restarts on the next plane.
  - DISPLAY: oe_=0 while timer>0; oe_ returns to 1 the cycle after the count expires.
  - BLANK is entered when the shifter is done and the timer is expired.
- **Pixel data:** hub75_r0..b1 are updated only in phase 2 and are otherwise held.
- **Widths:**
  - The timer is wide enough for OE_BASE<<(BITS-1) with no truncation.
  - rd_addr wraps naturally and never exceeds 2*ROW_ADDRS*COLS-1.
- **enable low:**
  - The current shift and display complete.
  - No new LATCH occurs; the block then holds oe_=1, lat=0, clk=0.
  - When enable rises again, scanning resumes with the already-shifted plane and goes straight to BLANK.
- **Reset mid-operation:** on the next edge all state aborts. The panel is blanked immediately (oe_=1) and the block restarts at (row 0, bit 0) with column 0.

## Timing
- **Reset values:** hub75_clk=0, hub75_lat=0, hub75_oe_=1, hub75_row=0, all colour bits 0, rd_addr=0, frame_start=0.
- **First plane** (cycle 0 = first cycle with reset low and enable high):
  - Column c occupies cycles 4c..4c+3.
  - Last hub75_clk high at 4*COLS-1.
  - BLANK at 4*COLS; LATCH at 4*COLS+1; oe_ low at cycles 4*COLS+2 .. 4*COLS+1+OE_BASE.
- **Steady state:**
  - Plane period = max(4*COLS, OE_BASE<<b_prev) + 2 cycles.
  - oe_ is never low during BLANK, LATCH or a hub75_row change.
- hub75_lat and hub75_clk are never high in the same cycle.
- Read latency is fixed at 1 cycle; there is no backpressure.

## Test plan
- **Reset:** hold reset 5 cycles → all outputs at their reset values. Release → first hub75_lat at cycle 257 (defaults), with hub75_row=0 and frame_start=1 in that cycle.
- **Pattern:** frame buffer model with pixel n = {n[7:0], ~n[7:0], n[7:0]} → a panel shift-register model captures, for each plane, the bits of addresses r*64+c and (r+8)*64+c that match the model. Rebuilding a full frame reproduces the RAM contents for all 1024 pixels.
- **BCM weights:** measure oe_-low run length per latch → 8, 16, 32, …, 1024 cycles for bits 0..7, repeating per row. hub75_row sequence is 0..7, each row held for 8 latches.
- **Frame wrap:** run 64 latches → frame_start pulses exactly on latch 0 and latch 64. hub75_row goes 7→0 only while oe_=1.
- **Enable:** drop enable mid-shift of plane (3,5) → that plane finishes shifting, no further lat, oe_ stays 1. Raise enable → lat follows within 2 cycles with hub75_row=3.
- **Reset mid-display:** assert reset during a bit-7 display → oe_=1 on the next edge. After release, hub75_row=0 and the first latch again occurs at cycle 257.
